quick_rs232_tx_arbiter: RTL
===========================

QUICK_RS232_TX_ARBITER -- requirements
Module: quick_rs232_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, byte width matching the quick_rs232 tx_data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4340, max cycles a grant waits mid-packet for the next byte.
REQ-004 SHALL have ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  NUM_REQ*DATA_WIDTH  per-requester byte; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  byte is the last of its packet.
- req_ready  out  NUM_REQ  one-cycle pulse: byte consumed.
- grant  out  NUM_REQ  one-hot current owner, all-zero when idle.
- tx_transaction  out  1  to quick_rs232.
- tx_data  out  DATA_WIDTH  to quick_rs232.
- tx_data_ready  out  1  to quick_rs232.
- tx_data_copied  in  1  from quick_rs232; one-cycle pulse.
- tx_busy  in  1  from quick_rs232.
- timeout_err  out  1  one-cycle pulse on grant abort.

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, WAIT_COPY, DRAIN, RELEASE.
REQ-006 IDLE: with any req_valid high, SHALL select a requester round-robin starting at (last_owner+1) mod NUM_REQ, set grant one-hot and tx_transaction=1 on the next edge, and go to LOAD.
REQ-007 LOAD with req_valid[owner]=1: SHALL register tx_data<=req_data[owner], set tx_data_ready=1, clear the timeout counter, capture req_last[owner], and go to WAIT_COPY.
REQ-008 LOAD with req_valid[owner]=0: SHALL increment the timeout counter; at TIMEOUT_CYCLES-1 SHALL pulse timeout_err and go to RELEASE.
REQ-009 WAIT_COPY: SHALL hold tx_data and tx_data_ready=1 until tx_data_copied=1, then SHALL drop tx_data_ready and pulse req_ready[owner] for exactly one cycle on the next edge.
REQ-010 On exit from WAIT_COPY: captured last=1 SHALL go to DRAIN; otherwise SHALL go to LOAD.
REQ-011 DRAIN: SHALL wait for tx_busy=0, sampled no earlier than 2 cycles after entry, then go to RELEASE.
REQ-012 RELEASE: SHALL clear tx_transaction and grant, store last_owner, and go to IDLE; total 1 cycle.
REQ-013 SHALL let no requester other than the owner receive req_ready or have its data sampled while grant is held.
REQ-014 Fairness: with all requesters continuously valid, grants SHALL rotate 0,1,...,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 packets.
REQ-015 SHALL ignore a tx_data_copied pulse outside WAIT_COPY.
REQ-016 SHALL ignore req_valid deasserting in WAIT_COPY, because the byte is already registered.
REQ-017 Timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1); the counter SHALL saturate and never wrap.
REQ-018 Back-to-back packets from the same sole requester SHALL be granted again with at least one IDLE cycle between them.

Reset
REQ-019 On rst=0 at any time, including mid-packet, SHALL force:
- state IDLE
- grant=0, req_ready=0, tx_transaction=0, tx_data=0, tx_data_ready=0, timeout_err=0
- last_owner=NUM_REQ-1, so requester 0 wins first
- timeout counter 0
REQ-020 Outputs SHALL stay at reset values until the first clk edge after rst returns high.

Structure
REQ-021 FSM state encodings and the round-robin pick function SHALL reside in shared package quick_rs232_pkg.
REQ-022 Round-robin selection SHALL be one sub-module, quick_rs232_rr_picker (inputs request vector and last_owner; outputs one-hot grant and valid), purely combinational.
REQ-023 The arbiter SHALL contain all sequential logic; the total SHALL be 120-400 RTL lines.

Verification
REQ-024 Single packet: req_valid[2]=1, bytes 8'h53 then 8'hA5 with last set on the second byte; model copy latency 3 cycles. Expected: grant=4'b0100, tx_data 8'h53 then 8'hA5, two req_ready[2] pulses, then tx_transaction drops after tx_busy=0.
REQ-025 Contention: all 4 requesters valid with single-byte packets. Expected: grant order 0,1,2,3,0 and exactly one req_ready per packet to the correct index.
REQ-026 Starvation: requester 1 sends a non-last byte, then drops valid for TIMEOUT_CYCLES cycles. Expected: one timeout_err pulse, grant=0, and requester 3 (pending) granted next.
REQ-027 Reset mid-packet: assert rst=0 during WAIT_COPY. Expected: all outputs zero asynchronously; after release, requester 0 wins first.
REQ-028 Spurious tx_data_copied pulse in IDLE or DRAIN. Expected: no req_ready and no state change.
REQ-029 Integrated with quick_rs232 at 50 MHz/115200: serialized tx line bits SHALL match the granted bytes in order.

Source files
------------

// File: rtl/quick_rs232_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : quick_rs232_pkg
// Purpose  : Shared definitions for the quick_rs232 transmit arbiter: FSM
//            state encodings and the round-robin pick / one-hot index helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package quick_rs232_pkg;

  // Upper bound on the number of requesters the helpers can handle.
  localparam int MAX_REQ = 8;

  // Arbiter FSM encodings.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_WAIT_COPY = 3'd2;
  localparam logic [2:0] ST_DRAIN     = 3'd3;
  localparam logic [2:0] ST_RELEASE   = 3'd4;

  // Round-robin pick: returns a one-hot vector selecting the first set
  // request at or after (last_owner+1) mod num_req. The walk runs from the
  // farthest candidate to the nearest so the nearest one overwrites the rest.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         last_owner,
    input int                 num_req
  );
    logic [MAX_REQ-1:0] pick;
    logic [2:0]         idx;
    pick = '0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= num_req) begin
        idx = 3'((int'(last_owner) + k) % num_req);
        if (req[idx]) begin
          pick      = '0;
          pick[idx] = 1'b1;
        end
      end
    end
    return pick;
  endfunction

  // Index of the set bit in a one-hot vector (0 when the vector is empty).
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (onehot[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/quick_rs232_rr_picker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : quick_rs232_rr_picker
// Purpose  : Purely combinational round-robin requester selection.
// Ports    : req        - request vector, one bit per requester
//            last_owner - index of the previous grant holder
//            grant      - one-hot selected requester (zero if none)
//            valid      - at least one requester selected
// Revision : 1.0 - initial release
// ============================================================================
module quick_rs232_rr_picker
  import quick_rs232_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  logic [MAX_REQ-1:0] w_req_ext;
  logic [MAX_REQ-1:0] w_pick;

  assign w_req_ext = MAX_REQ'(req);
  assign w_pick    = rr_pick(w_req_ext, 3'(last_owner), NUM_REQ);
  assign grant     = w_pick[NUM_REQ-1:0];
  assign valid     = |w_pick;

endmodule
`default_nettype wire

// File: rtl/quick_rs232_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : quick_rs232_tx_arbiter
// Purpose  : Packet-level round-robin arbiter feeding bytes from NUM_REQ
//            requesters into a single quick_rs232 transmitter. A grant is
//            held for a whole packet and released once the UART has drained.
// Ports    : clk, rst (async, active-low)
//            req_valid/req_data/req_last  - per-requester byte stream
//            req_ready                    - one-cycle "byte consumed" pulse
//            grant                        - one-hot current owner
//            tx_transaction/tx_data/tx_data_ready - towards quick_rs232
//            tx_data_copied/tx_busy       - from quick_rs232
//            timeout_err                  - pulse when a stalled grant aborts
// Revision : 1.0 - initial release
// ============================================================================
module quick_rs232_tx_arbiter
  import quick_rs232_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4340
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          tx_transaction,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_data_ready,
  input  logic                          tx_data_copied,
  input  logic                          tx_busy,
  output logic                          timeout_err
);

  localparam int c_idx_w = $clog2(NUM_REQ);
  localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_max  = {c_tmo_w{1'b1}};

  logic [2:0]            r_state;
  logic [NUM_REQ-1:0]    r_grant;
  logic [c_idx_w-1:0]    r_owner;
  logic [c_idx_w-1:0]    r_last_owner;
  logic [NUM_REQ-1:0]    r_req_ready;
  logic                  r_tx_transaction;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_data_ready;
  logic                  r_timeout_err;
  logic                  r_last_cap;
  logic [c_tmo_w-1:0]    r_tmo_cnt;
  logic [1:0]            r_drain_cnt;

  logic [NUM_REQ-1:0]    w_pick_grant;
  logic                  w_pick_valid;
  logic [DATA_WIDTH-1:0] w_data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  quick_rs232_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req        (req_valid),
    .last_owner (r_last_owner),
    .grant      (w_pick_grant),
    .valid      (w_pick_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= ST_IDLE;
      r_grant          <= '0;
      r_owner          <= '0;
      r_last_owner     <= c_idx_w'(NUM_REQ - 1);
      r_req_ready      <= '0;
      r_tx_transaction <= 1'b0;
      r_tx_data        <= '0;
      r_tx_data_ready  <= 1'b0;
      r_timeout_err    <= 1'b0;
      r_last_cap       <= 1'b0;
      r_tmo_cnt        <= '0;
      r_drain_cnt      <= '0;
    end else begin
      // Both are single-cycle pulses.
      r_req_ready   <= '0;
      r_timeout_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_tmo_cnt <= '0;
          if (w_pick_valid) begin
            r_grant          <= w_pick_grant;
            r_owner          <= c_idx_w'(onehot_to_idx(MAX_REQ'(w_pick_grant)));
            r_tx_transaction <= 1'b1;
            r_state          <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          // While req_ready is still pulsing the requester has not yet had
          // an edge to advance its byte, so its bus shows the byte just sent.
          // Skip that cycle rather than sample it twice.
          if (r_req_ready != '0) begin
            r_tmo_cnt <= r_tmo_cnt;
          end else if (req_valid[r_owner]) begin
            r_tx_data       <= w_data_arr[r_owner];
            r_tx_data_ready <= 1'b1;
            r_tmo_cnt       <= '0;
            r_last_cap      <= req_last[r_owner];
            r_state         <= ST_WAIT_COPY;
          end else if (r_tmo_cnt == c_tmo_last) begin
            r_timeout_err <= 1'b1;
            r_state       <= ST_RELEASE;
          end else if (r_tmo_cnt != c_tmo_max) begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
          end
        end

        ST_WAIT_COPY: begin
          // Byte is already registered, so req_valid is not looked at here.
          if (tx_data_copied) begin
            r_tx_data_ready <= 1'b0;
            r_req_ready     <= r_grant;
            r_drain_cnt     <= '0;
            r_state         <= r_last_cap ? ST_DRAIN : ST_LOAD;
          end
        end

        ST_DRAIN: begin
          // The UART may need a couple of cycles to raise tx_busy after the
          // copy, so do not trust tx_busy until two cycles into DRAIN.
          if (r_drain_cnt != 2'd2) begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
          end else if (!tx_busy) begin
            r_state <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          r_tx_transaction <= 1'b0;
          r_grant          <= '0;
          r_last_owner     <= r_owner;
          r_state          <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready      = r_req_ready;
  assign grant          = r_grant;
  assign tx_transaction = r_tx_transaction;
  assign tx_data        = r_tx_data;
  assign tx_data_ready  = r_tx_data_ready;
  assign timeout_err    = r_timeout_err;

endmodule
`default_nettype wire
